cond_exec_e: RTL
================

Name: cond_exec_e

Overview:
- Execute-stage control block of the 5-stage pipeline.
- Holds the decode-to-execute control pipeline register and the architectural NZCV flags register.
- Evaluates the instruction's 4-bit condition field against the current flags and gates the side-effecting controls (PCSrcE, RegWriteE, MemWriteE, BranchTakenE).
- Its outputs feed the E/M control register and the hazard unit directly.

Parameters:
- COND_W, 4, width of the condition field.
- FLAG_W, 4, width of the flags vector {N,Z,C,V}.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  reset, asynchronous, active-high.
- en  input  1  stage enable; 0 = stall, hold the D/E register and flags.
- flushE  input  1  synchronous bubble insert into the D/E register.
- PCSrcD  input  1  decode: instruction writes PC.
- RegWriteD  input  1  decode: register-file write.
- MemtoRegD  input  1  decode: result comes from memory.
- MemWriteD  input  1  decode: data-memory write.
- BranchD  input  1  decode: branch instruction.
- FlagWriteD  input  2  decode: [1] updates N,Z; [0] updates C,V.
- CondD  input  COND_W  decode: condition field.
- ALUFlags  input  FLAG_W  combinational {N,Z,C,V} from the execute ALU.
- PCSrcE  output  1  gated PC-write control.
- RegWriteE  output  1  gated register write.
- MemtoRegE  output  1  ungated copy of the registered MemtoReg.
- MemWriteE  output  1  gated memory write.
- BranchTakenE  output  1  gated branch.
- CondExE  output  1  condition passed for the instruction now in E.
- FlagsE  output  FLAG_W  current flags register {N,Z,C,V}.

Behaviour:

D/E register
- Holds PCSrc, RegWrite, MemtoReg, MemWrite, Branch, FlagWrite[1:0] and Cond[3:0].
- On reset: every D/E bit is 0 and FlagsE = 4'b0000. All gated outputs, MemtoRegE and CondExE are therefore 0 (Cond=EQ with Z=0 fails).
- Rising edge with flushE=1: all control bits and FlagWrite clear to 0, Cond loads 4'b0000. flushE has priority over en, so it applies even when en=0.
- Rising edge with flushE=0, en=1: all D inputs are captured.
- Rising edge with flushE=0, en=0: the register holds.

Condition evaluation
- Purely combinational on the registered Cond and FlagsE (pre-update value); there is no flag forwarding from ALUFlags.
- Encoding:
  - 0 EQ: Z
  - 1 NE: !Z
  - 2 CS: C
  - 3 CC: !C
  - 4 MI: N
  - 5 PL: !N
  - 6 VS: V
  - 7 VC: !V
  - 8 HI: C&!Z
  - 9 LS: !C|Z
  - 10 GE: N==V
  - 11 LT: N!=V
  - 12 GT: !Z&(N==V)
  - 13 LE: Z|(N!=V)
  - 14 AL: 1
  - 15: 0 (reserved, never executes).

Gating (combinational, zero latency from the register outputs)
- PCSrcE, RegWriteE, MemWriteE and BranchTakenE each equal the corresponding registered bit AND CondExE.
- MemtoRegE is the registered bit, ungated.

Flags register
- On a rising edge with en=1 and CondExE=1:
  - if the registered FlagWrite[1]=1: N,Z load ALUFlags[3:2];
  - if the registered FlagWrite[0]=1: C,V load ALUFlags[1:0].
- Otherwise the flags hold, including during a stall (en=0), so a stalled instruction never writes flags twice.
- The flush and the flags update occur on the same edge independently. The update uses the instruction leaving E, then the bubble enters.
- Back-to-back flag setters: the second instruction's condition sees the first one's flags (one-cycle latency, no bypass).

Reset mid-operation
- Asynchronous clear of both the D/E register and the flags in the same instant.
- Outputs drop to 0 without waiting for a clock edge.

Test Plan:
1. Reset with D inputs all 1 and CondD=14 -> after reset release, before any edge: all outputs 0, FlagsE=0000; after one edge: PCSrcE=RegWriteE=MemWriteE=BranchTakenE=MemtoRegE=1, CondExE=1.
2. Flag setting: FlagWriteD=2'b11, CondD=14, ALUFlags=4'b0100 -> next cycle FlagsE=0100; following instruction CondD=0 (EQ) with RegWriteD=1 -> RegWriteE=1; with CondD=1 (NE) -> RegWriteE=0, CondExE=0.
3. Partial write: FlagsE=1111, FlagWrite=2'b01, ALUFlags=0000 -> FlagsE=1100. A failing condition (CondD=15) with FlagWrite=2'b11 -> FlagsE unchanged.
4. Signed compares: FlagsE=1001 (N=1,V=1,Z=0) -> GT passes, LT fails. FlagsE=1000 -> LT and LE pass, GE fails. FlagsE=0010 -> HI passes; FlagsE=0110 -> LS passes.
5. Stall: en=0 for 3 cycles while the E instruction has FlagWrite=11, AL, ALUFlags varying -> D/E and FlagsE constant; flags update exactly once on the first edge after en returns to 1.
6. Flush vs stall: en=0, flushE=1 with BranchD=1 loaded -> next cycle all gated outputs 0, Cond reads as EQ. Assert reset mid-cycle with PCSrcE=1 -> PCSrcE falls immediately, before the next clk edge.

Source files
------------

// File: rtl/cond_exec_e_if.sv
// ----------------------------------------------------------------------------
// cond_exec_e_if
//   Bundle between the decode/hazard side and the execute-stage control block.
//   It carries the stage controls (en, flushE), the decoded control word
//   entering the D/E register, the combinational ALU flags, and the gated
//   execute-stage controls leaving the block.
//
//   Modports
//     master : pipeline side, drives decode controls and ALUFlags, observes the
//              gated E-stage outputs.
//     slave  : cond_exec_e, consumes the decode controls and drives the outputs.
//
//   Signals
//     en, flushE            stage enable (0 = stall) / synchronous bubble insert
//     PCSrcD .. CondD       decoded control word for the instruction entering E
//     ALUFlags              {N,Z,C,V} produced by the execute ALU this cycle
//     PCSrcE .. BranchTakenE gated side-effecting controls
//     MemtoRegE             ungated registered MemtoReg
//     CondExE               condition passed for the instruction now in E
//     FlagsE                architectural flags register {N,Z,C,V}
// ----------------------------------------------------------------------------
interface cond_exec_e_if #(
  parameter int COND_W = 4,
  parameter int FLAG_W = 4
);
  // Stage control
  logic              en;
  logic              flushE;

  // Decode-side control word
  logic              PCSrcD;
  logic              RegWriteD;
  logic              MemtoRegD;
  logic              MemWriteD;
  logic              BranchD;
  logic [1:0]        FlagWriteD;
  logic [COND_W-1:0] CondD;

  // Combinational flags from the execute ALU
  logic [FLAG_W-1:0] ALUFlags;

  // Execute-side results
  logic              PCSrcE;
  logic              RegWriteE;
  logic              MemtoRegE;
  logic              MemWriteE;
  logic              BranchTakenE;
  logic              CondExE;
  logic [FLAG_W-1:0] FlagsE;

  modport master (
    output en, flushE,
    output PCSrcD, RegWriteD, MemtoRegD, MemWriteD, BranchD, FlagWriteD, CondD,
    output ALUFlags,
    input  PCSrcE, RegWriteE, MemtoRegE, MemWriteE, BranchTakenE, CondExE, FlagsE
  );

  modport slave (
    input  en, flushE,
    input  PCSrcD, RegWriteD, MemtoRegD, MemWriteD, BranchD, FlagWriteD, CondD,
    input  ALUFlags,
    output PCSrcE, RegWriteE, MemtoRegE, MemWriteE, BranchTakenE, CondExE, FlagsE
  );
endinterface

// File: rtl/cond_exec_e.sv
// ----------------------------------------------------------------------------
// cond_exec_e
//   Execute-stage control block of the 5-stage pipeline.
//   - Holds the decode-to-execute control register (D/E).
//   - Holds the architectural NZCV flags register.
//   - Evaluates the registered condition field against the current flags and
//     gates the side-effecting controls (PC write, register write, memory
//     write, branch taken). The gated outputs feed the E/M register and the
//     hazard unit directly, so they are combinational from the registers.
//
//   Ports
//     clk    : rising-edge clock for all state
//     reset  : asynchronous, active-high clear of the D/E register and flags
//     bus    : cond_exec_e_if.slave (see interface header for signal list)
// ----------------------------------------------------------------------------
module cond_exec_e #(
  parameter int COND_W = 4,
  parameter int FLAG_W = 4
) (
  input  logic          clk,
  input  logic          reset,
  cond_exec_e_if.slave  bus
);

  // --------------------------------------------------------------------------
  // Condition field encoding
  // --------------------------------------------------------------------------
  typedef enum logic [COND_W-1:0] {
    CondEq = 4'd0,   // Z
    CondNe = 4'd1,   // !Z
    CondCs = 4'd2,   // C
    CondCc = 4'd3,   // !C
    CondMi = 4'd4,   // N
    CondPl = 4'd5,   // !N
    CondVs = 4'd6,   // V
    CondVc = 4'd7,   // !V
    CondHi = 4'd8,   // C & !Z
    CondLs = 4'd9,   // !C | Z
    CondGe = 4'd10,  // N == V
    CondLt = 4'd11,  // N != V
    CondGt = 4'd12,  // !Z & (N == V)
    CondLe = 4'd13,  // Z | (N != V)
    CondAl = 4'd14,  // always
    CondNv = 4'd15   // reserved: never executes
  } condCode_t;

  // Bit positions inside the {N,Z,C,V} flags vector
  localparam int NBit = FLAG_W - 1;
  localparam int ZBit = FLAG_W - 2;
  localparam int CBit = FLAG_W - 3;
  localparam int VBit = FLAG_W - 4;

  // --------------------------------------------------------------------------
  // D/E control register
  // --------------------------------------------------------------------------
  typedef struct packed {
    logic              pcSrc;
    logic              regWrite;
    logic              memtoReg;
    logic              memWrite;
    logic              branch;
    logic [1:0]        flagWrite;   // [1] updates N,Z; [0] updates C,V
    logic [COND_W-1:0] cond;
  } deCtrl_t;

  deCtrl_t           deReg;
  deCtrl_t           deNext;
  logic [FLAG_W-1:0] flagsReg;
  logic              condEx;

  assign deNext = '{
    pcSrc:     bus.PCSrcD,
    regWrite:  bus.RegWriteD,
    memtoReg:  bus.MemtoRegD,
    memWrite:  bus.MemWriteD,
    branch:    bus.BranchD,
    flagWrite: bus.FlagWriteD,
    cond:      bus.CondD
  };

  // A flush loads an all-zero word: every control bit off and Cond = EQ.
  // It wins over a stall so a bubble can be inserted while the stage is held.
  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      deReg <= '0;
    end else if (bus.flushE) begin
      deReg <= '0;
    end else if (bus.en) begin
      deReg <= deNext;
    end
  end

  // --------------------------------------------------------------------------
  // Condition evaluation on the registered Cond and the current (pre-update)
  // flags. There is deliberately no forwarding from ALUFlags: a flag setter
  // is visible to the following instruction one cycle later.
  // --------------------------------------------------------------------------
  logic flagN, flagZ, flagC, flagV;

  assign flagN = flagsReg[NBit];
  assign flagZ = flagsReg[ZBit];
  assign flagC = flagsReg[CBit];
  assign flagV = flagsReg[VBit];

  // NOTE: condEx gets a default before the case so every path assigns it and
  // no latch is inferred even if the case list were ever incomplete.
  always_comb begin
    condEx = 1'b0;
    case (deReg.cond)
      CondEq:  condEx = flagZ;
      CondNe:  condEx = ~flagZ;
      CondCs:  condEx = flagC;
      CondCc:  condEx = ~flagC;
      CondMi:  condEx = flagN;
      CondPl:  condEx = ~flagN;
      CondVs:  condEx = flagV;
      CondVc:  condEx = ~flagV;
      CondHi:  condEx = flagC & ~flagZ;
      CondLs:  condEx = ~flagC | flagZ;
      CondGe:  condEx = (flagN == flagV);
      CondLt:  condEx = (flagN != flagV);
      CondGt:  condEx = ~flagZ & (flagN == flagV);
      CondLe:  condEx = flagZ | (flagN != flagV);
      CondAl:  condEx = 1'b1;
      CondNv:  condEx = 1'b0;
      default: condEx = 1'b0;
    endcase
  end

  // --------------------------------------------------------------------------
  // Flags register
  //   Updated only by an executing (condition-passed) instruction while the
  //   stage advances. Holding during a stall guarantees a stalled setter
  //   writes the flags exactly once, on the edge where it finally leaves E.
  //   This is independent of flushE: on a flush edge the departing
  //   instruction still updates the flags and the bubble enters behind it.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flagsReg <= '0;
    end else if (bus.en && condEx) begin
      if (deReg.flagWrite[1]) begin
        flagsReg[NBit] <= bus.ALUFlags[NBit];
        flagsReg[ZBit] <= bus.ALUFlags[ZBit];
      end
      if (deReg.flagWrite[0]) begin
        flagsReg[CBit] <= bus.ALUFlags[CBit];
        flagsReg[VBit] <= bus.ALUFlags[VBit];
      end
    end
  end

  // --------------------------------------------------------------------------
  // Outputs: zero-latency gating from the register outputs. MemtoReg has no
  // side effect of its own (it only selects the writeback source), so it is
  // passed through ungated.
  // --------------------------------------------------------------------------
  assign bus.PCSrcE       = deReg.pcSrc    & condEx;
  assign bus.RegWriteE    = deReg.regWrite & condEx;
  assign bus.MemWriteE    = deReg.memWrite & condEx;
  assign bus.BranchTakenE = deReg.branch   & condEx;
  assign bus.MemtoRegE    = deReg.memtoReg;
  assign bus.CondExE      = condEx;
  assign bus.FlagsE       = flagsReg;

endmodule
